// File: rtl/idli_sqi_ctrl_if.sv
// Request/response port of the idli SQI memory controller.
// The core drives the master side; the controller implements the slave side.
interface idli_sqi_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data
  );
endinterface

// File: rtl/idli_sqi_ctrl.sv
// SQI word controller: cmd, 24-bit addr, dummy, 4 data nibbles.
// Define SQI_BURST_EN to keep CS# low for sequential words (BHOLD).
module idli_sqi_ctrl #(
  parameter int         DUMMY_NIBBLES = 2,
  parameter int         CS_GAP        = 2,
  parameter logic [7:0] CMD_READ      = 8'h03,
  parameter logic [7:0] CMD_WRITE     = 8'h02
) (
  input  logic         clk,
  input  logic         rst_n,
  idli_sqi_ctrl_if.slave bus,
  output logic         sqi_sck,
  output logic         sqi_cs_n,
  output logic [3:0]   sqi_sd_out,
  output logic [3:0]   sqi_sd_oe,
  input  logic [3:0]   sqi_sd_in
);

  localparam logic [3:0] LDUM = 4'(DUMMY_NIBBLES);
  localparam logic [3:0] LGAP = 4'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
`ifdef SQI_BURST_EN
    , S_BHOLD
`endif
  } st_t;

  st_t         r_st, w_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_ph, w_ph_nx;
  logic        r_pend, w_pend_nx;
  logic        r_we;
  logic [15:0] r_addr, r_wdata;
  logic [11:0] r_rx;
  logic        r_smp, r_done;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        w_acc, w_done, w_smp, w_rdy;
  logic        w_sck, w_cs_n;
  logic [3:0]  w_oe, w_sd;
  logic [31:0] w_hdr;
  logic [3:0]  w_hdr_nib, w_wd_nib;
  logic        w_seq;

  assign w_hdr = {r_we ? CMD_WRITE : CMD_READ,
                  7'b0, r_addr, 1'b0};
  assign w_hdr_nib = w_hdr[{~r_cnt[2:0], 2'b11} -: 4];
  assign w_wd_nib  = r_wdata[{~r_cnt[1:0], 2'b11} -: 4];

`ifdef SQI_BURST_EN
  // 17-bit compare so 16'hFFFF -> 16'h0000 is not sequential
  assign w_seq = (bus.req_we == r_we) &&
                 (({1'b0, r_addr} + 17'd1) ==
                  {1'b0, bus.req_addr});
`else
  assign w_seq = 1'b0;
`endif

  assign bus.req_ready = w_rdy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  always_comb begin
    w_nx      = r_st;
    w_cnt_nx  = r_cnt;
    w_ph_nx   = 1'b0;
    w_pend_nx = r_pend;
    w_acc     = 1'b0;
    w_done    = 1'b0;
    w_smp     = 1'b0;
    w_rdy     = 1'b0;
    w_sck     = 1'b0;
    w_cs_n    = 1'b1;
    w_oe      = 4'h0;
    w_sd      = 4'h0;
    unique case (r_st)
      S_IDLE: begin
        w_rdy = 1'b1;
        if (bus.req_valid) begin
          w_acc    = 1'b1;
          w_cnt_nx = 4'd0;
          w_nx     = S_CMD;
        end
      end
      S_CMD, S_ADDR: begin
        w_cs_n  = 1'b0;
        w_sck   = r_ph;
        w_oe    = 4'hF;
        w_sd    = w_hdr_nib;
        w_ph_nx = ~r_ph;
        if (r_ph) begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd1) w_nx = S_ADDR;
          if (r_cnt == 4'd7) begin
            w_cnt_nx = 4'd0;
            w_nx = (!r_we && LDUM != 4'd0) ?
                   S_DUMMY : S_DATA;
          end
        end
      end
      S_DUMMY: begin
        w_cs_n  = 1'b0;
        w_sck   = r_ph;
        w_ph_nx = ~r_ph;
        if (r_ph) begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == LDUM - 4'd1) begin
            w_cnt_nx = 4'd0;
            w_nx     = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_cs_n  = 1'b0;
        w_sck   = r_ph;
        w_oe    = r_we ? 4'hF : 4'h0;
        w_sd    = r_we ? w_wd_nib : 4'h0;
        w_smp   = !r_we && r_ph;
        w_ph_nx = ~r_ph;
        if (r_ph) begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd3) begin
            w_done   = 1'b1;
            w_cnt_nx = 4'd0;
`ifdef SQI_BURST_EN
            w_nx = S_BHOLD;
`else
            w_nx = S_GAP;
`endif
          end
        end
      end
      S_GAP: begin
        if (r_cnt == LGAP) begin
          w_cnt_nx  = 4'd0;
          w_pend_nx = 1'b0;
          w_nx      = r_pend ? S_CMD : S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
`ifdef SQI_BURST_EN
      S_BHOLD: begin
        w_cs_n = 1'b0;
        w_rdy  = 1'b1;
        if (bus.req_valid) begin
          w_acc    = 1'b1;
          w_cnt_nx = 4'd0;
          if (w_seq) begin
            w_nx = S_DATA;
          end else begin
            w_nx      = S_GAP;
            w_pend_nx = 1'b1;
          end
        end
      end
`endif
      default: w_nx = S_IDLE;
    endcase
  end

  // Pins lag the FSM by one cycle; r_smp marks the edge ending pin phase H
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ph        <= 1'b0;
      r_pend      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_rx        <= 12'h000;
      r_smp       <= 1'b0;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      sqi_sck     <= 1'b0;
      sqi_cs_n    <= 1'b1;
      sqi_sd_out  <= 4'h0;
      sqi_sd_oe   <= 4'h0;
    end else begin
      r_st        <= w_nx;
      r_cnt       <= w_cnt_nx;
      r_ph        <= w_ph_nx;
      r_pend      <= w_pend_nx;
      r_smp       <= w_smp;
      r_done      <= w_done;
      r_rsp_valid <= r_done;
      sqi_sck     <= w_sck;
      sqi_cs_n    <= w_cs_n;
      sqi_sd_out  <= w_sd;
      sqi_sd_oe   <= w_oe;
      if (w_acc) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_smp) r_rx <= {r_rx[7:0], sqi_sd_in};
      if (r_done)
        r_rsp_data <= r_we ? 16'h0000 :
                      {r_rx, sqi_sd_in};
    end
  end

endmodule
